iobus_stream_fifo: RTL and testbench

MicroBlaze MCS IO bus slave that accepts 32-bit word writes from the CPU into a DEPTH-entry FIFO and presents them on a valid/ready stream output. It sits directly downstream of the IO bus master and is driven by the same bus-master model in benches. It exposes a status register and a flush control. When the FIFO is full it stalls the bus by withholding io_ready.

---
 rtl/iobus_pkg.sv | 41 ++++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/iobus_stream_fifo.sv | 150 +++++++++++++++
 tb/tb_iobus_stream_fifo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iobus_pkg.sv
// Shared definitions for the IO bus stream FIFO slave.
// Covers the register map, STATUS/CTRL bit positions and FSM encoding.
package iobus_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_ERR_BIT   = 2;
    localparam int STAT_LEVEL_LSB = 8;
    localparam int STAT_LEVEL_MSB = 16;

    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_ERR_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_SPACE = 2'd1,
        ST_ACK        = 2'd2
    } state_t;

    // Level field is 9 bits wide so it can hold 256 for the deepest FIFO.
    function automatic logic [31:0] pack_status(
        input logic       empty,
        input logic       full,
        input logic       err,
        input logic [8:0] level
    );
        logic [31:0] s;
        s = '0;
        s[STAT_EMPTY_BIT] = empty;
        s[STAT_FULL_BIT]  = full;
        s[STAT_ERR_BIT]   = err;
        s[STAT_LEVEL_MSB:STAT_LEVEL_LSB] = level;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with flush.
// Head word is read straight from the storage array so it is visible the cycle after a push.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [WIDTH-1:0]           o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_level = r_level;
    assign o_head  = r_mem[r_rd_ptr];

    // Flush wins over a same-cycle pop; a pop frees the slot a push into a full FIFO needs.
    assign w_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_push = i_push & (~o_full | w_pop) & ~i_flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/iobus_stream_fifo.sv
// MicroBlaze MCS IO bus slave feeding a FWFT word FIFO onto a valid/ready stream.
// Stalls the bus (withholds io_ready) while a DATA write waits for space.
module iobus_stream_fifo
    import iobus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hC000_0000,
    parameter int          DEPTH     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_addr_strobe,
    input  logic        io_read_strobe,
    input  logic        io_write_strobe,
    input  logic [3:0]  io_byte_en,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        io_ready,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready
);

    localparam int LW = $clog2(DEPTH) + 1;

    state_t       r_state;
    state_t       w_state_next;
    logic         r_ready;
    logic [31:0]  r_rdata;
    logic [31:0]  r_wdata;
    logic         r_err;

    logic         w_err_next;
    logic [31:0]  w_rdata_next;
    logic         w_latch;
    logic         w_push;
    logic [31:0]  w_push_data;
    logic         w_flush;
    logic         w_pop;
    logic [LW-1:0] w_level;
    logic         w_full;
    logic         w_empty;
    logic [31:0]  w_head;
    logic         w_hit;
    logic         w_start;
    logic [1:0]   w_off;
    logic         w_full_word;
    logic         w_unused;

    assign w_unused    = ^io_addr[1:0];
    assign w_hit       = (io_addr[31:4] == BASE_ADDR[31:4]);
    assign w_start     = io_addr_strobe & w_hit & (r_state == ST_IDLE);
    assign w_off       = io_addr[3:2];
    assign w_full_word = (io_byte_en == 4'b1111);
    assign w_pop       = m_ready & ~w_empty;

    assign io_ready     = r_ready;
    assign io_read_data = r_rdata;
    assign m_valid      = ~w_empty;
    assign m_data       = w_head;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (m_ready),
        .i_flush (w_flush),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_push_data  = io_write_data;
        w_flush      = 1'b0;
        w_err_next   = r_err;
        w_rdata_next = '0;
        w_latch      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_ACK;
                    if (io_write_strobe) begin
                        case (w_off)
                            REG_DATA: begin
                                if (!w_full_word) begin
                                    w_err_next = 1'b1;
                                end else if (!w_full || w_pop) begin
                                    w_push = 1'b1;
                                end else begin
                                    w_state_next = ST_WAIT_SPACE;
                                end
                            end
                            REG_CTRL: begin
                                w_flush = io_write_data[CTRL_FLUSH_BIT];
                                if (io_write_data[CTRL_CLR_ERR_BIT]) begin
                                    w_err_next = 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end else if (io_read_strobe && (w_off == REG_STATUS)) begin
                        // Sampled before any same-cycle pop lands.
                        w_rdata_next = pack_status(w_empty, w_full, r_err, 9'(w_level));
                    end
                end
            end
            ST_WAIT_SPACE: begin
                if (!w_full || w_pop) begin
                    w_push       = 1'b1;
                    w_push_data  = r_wdata;
                    w_state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next == ST_ACK);
            r_rdata <= w_rdata_next;
            r_err   <= w_err_next;
            if (w_latch) begin
                r_wdata <= io_write_data;
            end
        end
    end

endmodule

// File: tb/tb_iobus_stream_fifo.sv
// Directed bench for iobus_stream_fifo: bus-master tasks plus immediate-assertion checks.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
module tb_iobus_stream_fifo;

    localparam logic [31:0] BASE = 32'hC000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_addr_strobe;
    logic        io_read_strobe;
    logic        io_write_strobe;
    logic [3:0]  io_byte_en;
    logic [31:0] io_addr;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;
    logic        io_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iobus_stream_fifo #(
        .BASE_ADDR (BASE),
        .DEPTH     (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_byte_en      (io_byte_en),
        .io_addr         (io_addr),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One strobe cycle; returns 1 ns after the sampling edge with the bus idle again.
    task automatic bus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be);
        io_addr_strobe  = 1'b1;
        io_write_strobe = wr;
        io_read_strobe  = ~wr;
        io_addr         = addr;
        io_write_data   = data;
        io_byte_en      = be;
        step();
        io_addr_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_read_strobe  = 1'b0;
        io_addr         = '0;
        io_write_data   = '0;
        io_byte_en      = '0;
        $display("bus %s addr=0x%08h data=0x%08h be=%b -> ready=%b rdata=0x%08h",
                 wr ? "WR" : "RD", addr, data, be, io_ready, io_read_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        logic [31:0] exp_q[$];

        rst = 1'b0;
        io_addr_strobe = 1'b0; io_read_strobe = 1'b0; io_write_strobe = 1'b0;
        io_byte_en = '0; io_addr = '0; io_write_data = '0; m_ready = 1'b0;

        // Reset state
        repeat (3) step();
        check("reset io_ready", {31'b0, io_ready}, 32'd0);
        check("reset io_read_data", io_read_data, 32'd0);
        check("reset m_valid", {31'b0, m_valid}, 32'd0);
        rst = 1'b1;
        repeat (2) step();

        // STATUS after reset
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF);
        check("status0 ack", {31'b0, io_ready}, 32'd1);
        check("status0 data", io_read_data, 32'h0000_0001);
        check("status0 m_valid", {31'b0, m_valid}, 32'd0);
        step();
        check("status0 ack one cycle", {31'b0, io_ready}, 32'd0);
        check("rdata zero off ack", io_read_data, 32'd0);

        // Reserved register read: acked, zero data
        bus(1'b0, BASE + 32'hC, 32'h0, 4'hF);
        check("rsvd ack", {31'b0, io_ready}, 32'd1);
        check("rsvd data", io_read_data, 32'd0);
        step();

        // Two writes, then drain in order
        bus(1'b1, BASE, 32'hDEADBEEF, 4'hF);
        check("wr1 ack", {31'b0, io_ready}, 32'd1);
        check("wr1 m_valid", {31'b0, m_valid}, 32'd1);
        check("wr1 m_data", m_data, 32'hDEADBEEF);
        step();
        bus(1'b1, BASE, 32'h12345678, 4'hF);
        check("wr2 ack", {31'b0, io_ready}, 32'd1);
        step();
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF);
        check("status2", io_read_data, 32'h0000_0200);
        m_ready = 1'b1;
        check("head0", m_data, 32'hDEADBEEF);
        step();
        check("head1", m_data, 32'h12345678);
        check("head1 valid", {31'b0, m_valid}, 32'd1);
        step();
        check("drained valid", {31'b0, m_valid}, 32'd0);
        m_ready = 1'b0;
        step();

        // Fill to DEPTH, then a stalled 17th write
        for (int i = 0; i < 16; i++) begin
            bus(1'b1, BASE, 32'h1000_0000 + i, 4'hF);
            check("fill ack", {31'b0, io_ready}, 32'd1);
            step();
        end
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF);
        check("status full", io_read_data, 32'h0000_1002);
        step();
        bus(1'b1, BASE, 32'hA5A5A5A5, 4'hF);
        seen = io_ready;
        for (int k = 0; k < 4; k++) begin
            step();
            seen = seen | io_ready;
        end
        check("stall no ack", {31'b0, seen}, 32'd0);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("stall ack after pop", {31'b0, io_ready}, 32'd1);
        check("head after pop", m_data, 32'h1000_0001);
        step();
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF);
        check("status still full", io_read_data, 32'h0000_1002);
        for (int i = 1; i < 16; i++) exp_q.push_back(32'h1000_0000 + i);
        exp_q.push_back(32'hA5A5A5A5);
        m_ready = 1'b1;
        while (exp_q.size() > 0) begin
            check("drain word", m_data, exp_q.pop_front());
            step();
        end
        m_ready = 1'b0;
        check("drain empty", {31'b0, m_valid}, 32'd0);
        step();

        // Partial byte-enable DATA write sets err; CTRL clears it
        bus(1'b1, BASE, 32'hCAFEF00D, 4'b0011);
        check("partial ack", {31'b0, io_ready}, 32'd1);
        check("partial not pushed", {31'b0, m_valid}, 32'd0);
        step();
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF);
        check("status err", io_read_data, 32'h0000_0005);
        step();
        bus(1'b1, BASE + 32'h8, 32'h2, 4'hF);
        check("clr err ack", {31'b0, io_ready}, 32'd1);
        step();
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF);
        check("status err cleared", io_read_data, 32'h0000_0001);
        step();

        // Flush with 5 words loaded
        for (int i = 0; i < 5; i++) begin
            bus(1'b1, BASE, 32'hB000_0000 + i, 4'hF);
            step();
        end
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF);
        check("status5", io_read_data, 32'h0000_0500);
        step();
        bus(1'b1, BASE + 32'h8, 32'h1, 4'hF);
        check("flush ack", {31'b0, io_ready}, 32'd1);
        check("flush m_valid", {31'b0, m_valid}, 32'd0);
        step();
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF);
        check("status flushed", io_read_data, 32'h0000_0001);
        step();

        // Out-of-window read: never acked within the timeout
        bus(1'b0, BASE + 32'h20, 32'h0, 4'hF);
        seen = io_ready | (|io_read_data);
        for (int k = 0; k < 8; k++) begin
            step();
            seen = seen | io_ready | (|io_read_data);
        end
        check("oob no ack", {31'b0, seen}, 32'd0);

        // Reset during a WAIT_SPACE stall
        for (int i = 0; i < 16; i++) begin
            bus(1'b1, BASE, 32'hC000_0000 + i, 4'hF);
            step();
        end
        bus(1'b1, BASE, 32'h77777777, 4'hF);
        seen = io_ready;
        step();
        seen = seen | io_ready;
        step();
        seen = seen | io_ready;
        rst = 1'b0;
        #1;
        check("rst ready", {31'b0, io_ready}, 32'd0);
        check("rst m_valid", {31'b0, m_valid}, 32'd0);
        step();
        step();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            seen = seen | io_ready;
        end
        check("rst no ack ever", {31'b0, seen}, 32'd0);
        check("rst m_valid after", {31'b0, m_valid}, 32'd0);
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF);
        check("status after rst", io_read_data, 32'h0000_0001);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
